// File: rtl/multicycle_controller.sv
// Main control FSM and ALU decoder for the multicycle MIPS core.
// Optional bne support is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMREAD = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       branch;
  logic       br_cond;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

`ifdef MULTICYCLE_BNE_EN
  // Remembers whether the branch in flight is bne; captured while decoding.
  logic bne_q;

  always_ff @(posedge clk) begin
    if (reset)                bne_q <= 1'b0;
    else if (state == DECODE) bne_q <= (Op == OP_BNE);
  end

  assign br_cond = bne_q ? ~Zero : Zero;
`else
  assign br_cond = Zero;
`endif

  // Next-state logic
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
`ifdef MULTICYCLE_BNE_EN
          OP_BNE:       next_state = BRANCH;
`endif
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (Op == OP_LW) ? MEMREAD : MEMWR;
      MEMREAD: next_state = MEMWB;
      EXECUTE: next_state = ALUWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  // Moore output decode from the state register
  always_comb begin
    IorD          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    reg_write_raw = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    PCSrc         = 2'b00;
    pc_write      = 1'b0;
    branch        = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB      = 2'b01;
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMREAD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
      end
      MEMWR: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b10;
      end
      ALUWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB:  reg_write_raw = 1'b1;
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder
  always_comb begin
    ALUControl = 3'b010;
    case (alu_op)
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (Funct)
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  // Architectural write enables are suppressed while reset is asserted
  assign PCEn     = (pc_write | (branch & br_cond)) & ~reset;
  assign IRWrite  = ir_write_raw & ~reset;
  assign RegWrite = reg_write_raw & ~reset;
  assign MemWrite = mem_write_raw & ~reset;
  assign State    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control words
// are queued from a reference table and compared as the FSM steps.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .Zero      (Zero),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUControl(ALUControl),
    .PCSrc     (PCSrc),
    .PCEn      (PCEn),
    .State     (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          fails = 0;
  int          seq[8];
  logic        cur_bne = 1'b0;

  // Reference control word: {State,IorD,MemWrite,IRWrite,RegDst,MemtoReg,
  // RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc,PCEn}
  function automatic logic [18:0] golden(input int st, input logic rst);
    logic iord, mw, irw, rd, m2r, rw, sa, pcen;
    logic [1:0] sb, pcs;
    logic [2:0] ctl;
    iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; pcen = 0;
    sb = 2'b00; pcs = 2'b00; ctl = 3'b010;
    case (st)
      0:  begin sb = 2'b01; irw = 1; pcen = 1; end
      1:  sb = 2'b11;
      2, 9: begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin
        sa = 1;
        case (Funct)
          6'b100010: ctl = 3'b110;
          6'b100100: ctl = 3'b000;
          6'b100101: ctl = 3'b001;
          6'b101010: ctl = 3'b111;
          default:   ctl = 3'b010;
        endcase
      end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ctl = 3'b110; pcs = 2'b01; pcen = cur_bne ? ~Zero : Zero; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    if (rst) begin pcen = 0; irw = 0; rw = 0; mw = 0; end
    return {4'(st), iord, mw, irw, rd, m2r, rw, sa, sb, ctl, pcs, pcen};
  endfunction

  task automatic pop_compare();
    logic [18:0] e, o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
         ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn};
    total++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", t, o, e);
    end
  endtask

  task automatic check_now(input int st, input logic rst, input string tag);
    exp_q.push_back(golden(st, rst));
    tag_q.push_back(tag);
    pop_compare();
  endtask

  // Queue the expected words for the next n cycles, then compare each cycle.
  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(golden(seq[i], 1'b0));
      tag_q.push_back($sformatf("%s[%0d]", tag, i));
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      pop_compare();
    end
  endtask

  initial begin
    reset = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_now(0, 1'b1, "init_rst");
    reset = 1'b0; #1;
    check_now(0, 1'b0, "init_release");

    Op = 6'b100011; seq = '{1, 2, 3, 4, 0, 0, 0, 0}; run("lw", 5);

    Op = 6'b000000;
    Funct = 6'b100010; seq = '{1, 6, 7, 0, 0, 0, 0, 0}; run("r_sub", 4);
    Funct = 6'b101010; run("r_slt", 4);
    Funct = 6'b100000; run("r_add", 4);
    Funct = 6'b100100; run("r_and", 4);
    Funct = 6'b100101; run("r_or", 4);
    Funct = 6'b111111; run("r_unk", 4);

    Op = 6'b000100; seq = '{1, 8, 0, 0, 0, 0, 0, 0};
    Zero = 1'b1; run("beq_taken", 3);
    Zero = 1'b0; run("beq_not", 3);

    Op = 6'b001000; seq = '{1, 9, 10, 0, 0, 0, 0, 0}; run("addi", 4);
    Op = 6'b000010; seq = '{1, 11, 0, 0, 0, 0, 0, 0}; run("j", 3);
    Op = 6'b111111; seq = '{1, 0, 0, 0, 0, 0, 0, 0}; run("unknown", 2);

    Op = 6'b000101;
`ifdef MULTICYCLE_BNE_EN
    cur_bne = 1'b1; seq = '{1, 8, 0, 0, 0, 0, 0, 0};
    Zero = 1'b0; run("bne_taken", 3);
    Zero = 1'b1; run("bne_not", 3);
    cur_bne = 1'b0;
`else
    seq = '{1, 0, 0, 0, 0, 0, 0, 0};
    Zero = 1'b0; run("bne_nop", 2);
`endif
    Zero = 1'b0;

    // sw interrupted by reset in MEMWR, reset held for two edges
    Op = 6'b101011; seq = '{1, 2, 5, 0, 0, 0, 0, 0}; run("sw_pre", 3);
    reset = 1'b1; #1;
    check_now(5, 1'b1, "rst_in_memwr");
    @(negedge clk); #1; check_now(0, 1'b1, "rst_edge1");
    @(negedge clk); #1; check_now(0, 1'b1, "rst_edge2");
    reset = 1'b0; #1;
    check_now(0, 1'b0, "rst_released");

    seq = '{1, 2, 5, 0, 0, 0, 0, 0}; run("sw", 4);
    Op = 6'b111111; seq = '{1, 0, 0, 0, 0, 0, 0, 0}; run("final_nop", 2);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
